ram_read_arbiter: RTL
=====================

# ram_read_arbiter

Round-robin arbiter that shares the single read port of one `ram_simple_dual` instance among `N_REQ` requesters. It issues at most one read per cycle. A tag pipeline matched to the RAM read latency routes each returned word back to the requester that issued it. The block sits between the PE-side buffer-fetch clients and the RAM; the RAM write port is not touched.

## Interface
- `N_REQ`, 4, number of read requesters (2..16)
- `W`, 16, data width; must equal the RAM `w`
- `D`, 1024, RAM depth; used for the address range check
- `RD_LAT`, 1, RAM read latency in cycles (≥1); matches the RAM `dout_vld` delay

- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `req_vld`  in  N_REQ  per-requester read request
- `req_addr`  in  N_REQ*32  per-requester address; requester i uses bits [32*i+31:32*i]
- `req_rdy`  out  N_REQ  one-hot grant; a request is accepted when `req_vld[i] & req_rdy[i]`
- `rsp_vld`  out  N_REQ  one-hot response strobe
- `rsp_data`  out  W  response data, shared by all requesters
- `ram_re`  out  1  to RAM `re`
- `ram_read_addr`  out  32  to RAM `read_addr`
- `ram_dout_vld`  in  1  from RAM `dout_vld`
- `ram_dout`  in  W  from RAM `dout`
- `err_oob`  out  1  sticky flag: a request was accepted with address ≥ D
- `err_sync`  out  1  sticky flag: tag and `ram_dout_vld` disagreed

## Operation
- **Round-robin pointer.** `rr_ptr` (clog2(N_REQ) bits) names the highest-priority requester.
- **Grant selection.** Each cycle, grant index g = first i with `req_vld[i]`, scanning from `rr_ptr` upward modulo N_REQ.
- **Grant outputs.** If any request is pending: `req_rdy[g]`=1, `ram_re`=1, `ram_read_addr`=`req_addr[g]`. Otherwise `req_rdy`=0, `ram_re`=0, `ram_read_addr`=0.
- **Pointer update.** On a grant, `rr_ptr` <= (g+1) mod N_REQ. With no request, `rr_ptr` holds.
- **Tag pipeline.** A shift register of depth RD_LAT holds {valid, idx}. Stage 0 loads {`ram_re`, g} each cycle.
- **Response, in sync.** When the last tag stage is valid and `ram_dout_vld`=1: `rsp_vld[idx]`=1 and `rsp_data`=`ram_dout`. Otherwise `rsp_vld`=0 and `rsp_data`=0.
- **Response, out of sync.** If the last tag is valid but `ram_dout_vld`=0, or `ram_dout_vld`=1 with no valid tag: set `err_sync` and drop the response.
- **Out-of-range address.** Such a request is still accepted and issued; `err_oob` is set. The RAM truncates the address.
- **Error flags.** Both flags stay set until `rst`.
- **Requester rule.** A requester must hold `req_vld` and `req_addr` stable until accepted. The arbiter imposes no backpressure on responses.

## Timing
- **Reset values.** While `rst` is high, all outputs are 0; `rr_ptr`=0 and all tags are invalid.
- **Reset mid-operation.** In-flight tags are discarded. Words the RAM returns after reset deasserts with no valid tag set `err_sync`.
- **Grant path.** `req_rdy`, `ram_re` and `ram_read_addr` are combinational from `req_vld`, `req_addr` and `rr_ptr`, with zero-cycle acceptance.
- **Response latency.** The response appears exactly RD_LAT cycles after the accept cycle. For RD_LAT=1 it appears the next cycle.
- **Throughput.** One read per cycle sustained. With k requesters continuously pending, each is granted once every k cycles.
- **Single requester.** A lone continuous requester is granted every cycle.
- **Pointer wrap.** After granting N_REQ-1 the pointer wraps to 0.
- **Sticky errors.** `err_oob` and `err_sync` rise one cycle after the offending event.

## Structure
- **Package `ram_arb_pkg`:**
  - `rd_tag_t` struct {vld, idx}.
  - `IDX_W = $clog2(N_REQ)` helper function.
  - `ADDR_W = 32` constant.
- **Sub-module `rr_pick`:** combinational round-robin priority picker. Inputs `req`[N] and `ptr`. Outputs one-hot `gnt` and encoded `idx`.
- **Top level:** pointer register, tag shift register, error flags, address mux.

## Test plan
- **Reset.** Hold `rst` 3 cycles with all `req_vld`=1 → all outputs 0 during reset. The first grant after release goes to requester 0.
- **Fairness.** N_REQ=4, all `req_vld` high for 8 cycles → grant order 0,1,2,3,0,1,2,3. Each `rsp_vld[i]` arrives RD_LAT cycles after its grant with matching RAM data (model RAM preloaded with mem[a]=a).
- **Sparse requests.** Only requesters 1 and 3 request, continuously → alternating 1,3,1,3. Then only requester 2 → granted every cycle, `rsp_vld[2]` every cycle.
- **Out-of-range address.** Requester 0 issues address 1024 with D=1024 → accepted, `ram_read_addr`=1024, `err_oob`=1 next cycle and stays set.
- **RAM de-sync.** Force `ram_dout_vld`=0 when a tag is due → no `rsp_vld`, `err_sync`=1.
- **Reset mid-flight.** RD_LAT=3 with reads in flight; pulse `rst` → `rsp_vld` stays 0 and `rr_ptr` restarts at 0.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the RAM read-port arbiter.
package ram_arb_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned TAG_IDX_W = 4;

  typedef struct packed {
    logic                 vld;
    logic [TAG_IDX_W-1:0] idx;
  } rd_tag_t;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_read_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import ram_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int unsigned p;
    int unsigned d;
    int unsigned best_d;
    int unsigned best;
    p      = 32'(ptr);
    d      = 0;
    best_d = N;
    best   = 0;
    // Distance from ptr modulo N; smallest distance wins.
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        d = (i >= p) ? (i - p) : (i + N - p);
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    any = (best_d < N);
    gnt = any ? (N'(1) << best) : '0;
    idx = IW'(best);
  end

endmodule

// File: rtl/ram_read_arbiter.sv
// Round-robin arbiter sharing one RAM read port, with tag pipeline for response routing.
module ram_read_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned N_REQ  = 4,
  parameter int unsigned W      = 16,
  parameter int unsigned D      = 1024,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_vld,
  input  logic [N_REQ*32-1:0] req_addr,
  output logic [N_REQ-1:0]    req_rdy,
  output logic [N_REQ-1:0]    rsp_vld,
  output logic [W-1:0]        rsp_data,
  output logic                ram_re,
  output logic [31:0]         ram_read_addr,
  input  logic                ram_dout_vld,
  input  logic [W-1:0]        ram_dout,
  output logic                err_oob,
  output logic                err_sync
);

  localparam int unsigned IDX_W = idx_w(N_REQ);

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] g;
  logic [N_REQ-1:0] gnt;
  logic             any;
  logic             grant;
  rd_tag_t          tags [RD_LAT];
  rd_tag_t          last;

  rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
    .req (req_vld),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (g),
    .any (any)
  );

  // Grant is suppressed while reset is held so every output reads zero.
  assign grant = any & ~rst;
  assign last  = tags[RD_LAT-1];

  always_comb begin
    req_rdy       = grant ? gnt : '0;
    ram_re        = grant;
    ram_read_addr = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant && gnt[i]) ram_read_addr = req_addr[32*i +: 32];
    end
  end

  always_comb begin
    rsp_vld  = '0;
    rsp_data = '0;
    if (last.vld && ram_dout_vld) begin
      rsp_vld  = N_REQ'(1) << last.idx;
      rsp_data = ram_dout;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr   <= '0;
      err_oob  <= 1'b0;
      err_sync <= 1'b0;
      for (int unsigned i = 0; i < RD_LAT; i++) tags[i] <= '0;
    end else begin
      if (grant) rr_ptr <= (g == IDX_W'(N_REQ - 1)) ? '0 : g + 1'b1;
      tags[0].vld <= grant;
      tags[0].idx <= TAG_IDX_W'(g);
      for (int unsigned i = 1; i < RD_LAT; i++) tags[i] <= tags[i-1];
      if (grant && (ram_read_addr >= ADDR_W'(D))) err_oob <= 1'b1;
      if (last.vld != ram_dout_vld) err_sync <= 1'b1;
    end
  end

endmodule
